zpu_uart_bank: RTL

Multi-channel UART register bank for the ZPU memory bus. It decodes CPU accesses in the 0xF peripheral region and gives each channel a TX FIFO, an RX FIFO, a programmable baud divisor, interrupt enables and a sticky overrun flag. It drives CHANNELS external simple_uart instances through flat vector ports. Channel 0 DATA at 0xFFFFFFC0 keeps the legacy bit layout: bit9 rx valid, bit8 tx ready, [7:0] data.

---
 rtl/zpu_uart_bank_if.sv | 15 +
 rtl/zpu_uart_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zpu_uart_bank_if.sv
// ZPU memory bus as seen by a peripheral: one-cycle read/write strobes,
// completion signalled by mem_busy dropping low for one cycle.
interface zpu_uart_bank_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write;
  logic        mem_writeEnable;
  logic        mem_readEnable;
  logic [31:0] mem_read;
  logic        mem_busy;

  modport master (output mem_addr, mem_write, mem_writeEnable, mem_readEnable,
                  input  mem_read, mem_busy);
  modport slave  (input  mem_addr, mem_write, mem_writeEnable, mem_readEnable,
                  output mem_read, mem_busy);
endinterface

// File: rtl/zpu_uart_bank.sv
// Multi-channel UART register bank on the ZPU bus: per-channel TX/RX FIFOs, divisor, IEN, overrun.
// Accesses ack one cycle after the strobe; a DATA write to a full TX FIFO stalls until a TX pop frees space.
module zpu_uart_bank #(
  parameter int          CHANNELS        = 2,
  parameter int          RX_DEPTH_LOG2   = 4,
  parameter int          TX_DEPTH_LOG2   = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic                    clk,
  input  logic                    reset_in,
  zpu_uart_bank_if.slave          bus,
  output logic [8*CHANNELS-1:0]   uart_txdata,
  output logic [CHANNELS-1:0]     uart_txgo,
  input  logic [CHANNELS-1:0]     uart_txready,
  input  logic [8*CHANNELS-1:0]   uart_rxdata,
  input  logic [CHANNELS-1:0]     uart_rxint,
  output logic [16*CHANNELS-1:0]  uart_divisor,
  output logic                    irq
);
  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam int TXD = 1 << TX_DEPTH_LOG2;

  typedef enum logic [1:0] {B_IDLE, B_STALL, B_ACK} bus_st_t;
  typedef enum logic {T_IDLE, T_WAIT} tx_st_t;

  // Per-channel views padded to four slots so the bus mux indexes by raw address bits.
  logic [3:0]       rx_ne, tx_full, tx_idle, ovr, irq_src;
  logic [3:0][7:0]  rx_head, rx_cnt8, tx_cnt8;
  logic [3:0][15:0] div;
  logic [3:0][1:0]  ien;
  logic [3:0]       tx_push, rx_pop, div_we, ien_we, ovr_clr;
  logic [7:0]       push_byte;

  bus_st_t     bus_st_q, bus_st_d;
  logic [31:0] rdat_q, rdat_d;
  logic [1:0]  lat_ch_q, lat_ch_d;
  logic [7:0]  lat_dat_q, lat_dat_d;
  logic        irq_q, irq_d;

  logic       sel, hit, strobe;
  logic [1:0] ch, rsel;
  logic       unused_bits;

  assign ch     = bus.mem_addr[5:4];
  assign rsel   = bus.mem_addr[3:2];
  assign sel    = (bus.mem_addr[31:28] == 4'hF) && (bus.mem_addr[7:6] == 2'b11);
  assign hit    = sel && ({1'b0, ch} < 3'(CHANNELS));
  assign strobe = bus.mem_writeEnable | bus.mem_readEnable;
  assign unused_bits = ^{bus.mem_addr[27:8], bus.mem_addr[1:0], bus.mem_write[31:17]};

  always_comb begin
    bus_st_d  = bus_st_q;
    rdat_d    = rdat_q;
    lat_ch_d  = lat_ch_q;
    lat_dat_d = lat_dat_q;
    tx_push   = '0;
    rx_pop    = '0;
    div_we    = '0;
    ien_we    = '0;
    ovr_clr   = '0;
    push_byte = bus.mem_write[7:0];
    irq_d     = |irq_src;
    case (bus_st_q)
      B_STALL: begin
        push_byte = lat_dat_q;
        if (!tx_full[lat_ch_q]) begin
          tx_push[lat_ch_q] = 1'b1;
          bus_st_d          = B_ACK;
        end
      end
      default: begin
        bus_st_d = B_IDLE;
        if (strobe) begin
          bus_st_d = B_ACK;
          rdat_d   = '0;
          if (bus.mem_writeEnable) begin
            if (hit) begin
              case (rsel)
                2'd0: begin
                  if (tx_full[ch]) begin
                    bus_st_d  = B_STALL;
                    lat_ch_d  = ch;
                    lat_dat_d = bus.mem_write[7:0];
                  end else begin
                    tx_push[ch] = 1'b1;
                  end
                end
                2'd1:    ovr_clr[ch] = bus.mem_write[16];
                2'd2:    div_we[ch]  = 1'b1;
                default: ien_we[ch]  = 1'b1;
              endcase
            end
          end else if (hit) begin
            case (rsel)
              2'd0: begin
                rdat_d     = {22'd0, rx_ne[ch], !tx_full[ch], rx_ne[ch] ? rx_head[ch] : 8'd0};
                rx_pop[ch] = rx_ne[ch];
              end
              2'd1:    rdat_d = {12'd0, tx_full[ch], tx_idle[ch], rx_ne[ch], ovr[ch],
                                 tx_cnt8[ch], rx_cnt8[ch]};
              2'd2:    rdat_d = {16'd0, div[ch]};
              default: rdat_d = {30'd0, ien[ch]};
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      bus_st_q  <= B_IDLE;
      rdat_q    <= '0;
      lat_ch_q  <= '0;
      lat_dat_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      bus_st_q  <= bus_st_d;
      rdat_q    <= rdat_d;
      lat_ch_q  <= lat_ch_d;
      lat_dat_q <= lat_dat_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.mem_busy = (bus_st_q != B_ACK);
  assign bus.mem_read = rdat_q;
  assign irq          = irq_q;

  genvar c;
  generate
    for (c = 0; c < 4; c++) begin : g_ch
      if (c < CHANNELS) begin : g_on
        logic [7:0]               tx_mem_q [TXD];
        logic [7:0]               tx_mem_d [TXD];
        logic [7:0]               rx_mem_q [RXD];
        logic [7:0]               rx_mem_d [RXD];
        logic [TX_DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
        logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
        logic [RX_DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
        logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
        tx_st_t                   tx_st_q, tx_st_d;
        logic                     tx_wait_q, tx_wait_d, txgo_q, txgo_d, ovr_q, ovr_d, tx_pop, rx_push;
        logic [7:0]               txdata_q, txdata_d;
        logic [15:0]              div_q, div_d;
        logic [1:0]               ien_q, ien_d;

        // A push into a full RX FIFO is only accepted if the bus pops in the same cycle.
        assign rx_push = uart_rxint[c] && (!rx_cnt_q[RX_DEPTH_LOG2] || rx_pop[c]);

        always_comb begin
          tx_mem_d  = tx_mem_q;
          rx_mem_d  = rx_mem_q;
          tx_wp_d   = tx_wp_q;
          tx_rp_d   = tx_rp_q;
          rx_wp_d   = rx_wp_q;
          rx_rp_d   = rx_rp_q;
          tx_st_d   = tx_st_q;
          tx_wait_d = tx_wait_q;
          txdata_d  = txdata_q;
          txgo_d    = 1'b0;
          tx_pop    = 1'b0;
          ovr_d     = ovr_q;
          div_d     = div_q;
          ien_d     = ien_q;
          case (tx_st_q)
            T_IDLE: begin
              if ((tx_cnt_q != '0) && uart_txready[c]) begin
                tx_pop    = 1'b1;
                txgo_d    = 1'b1;
                txdata_d  = tx_mem_q[tx_rp_q];
                tx_rp_d   = tx_rp_q + 1'b1;
                tx_st_d   = T_WAIT;
                tx_wait_d = 1'b0;
              end
            end
            default: begin
              tx_wait_d = 1'b1;
              if (tx_wait_q) tx_st_d = T_IDLE;
            end
          endcase
          if (tx_push[c]) begin
            tx_mem_d[tx_wp_q] = push_byte;
            tx_wp_d           = tx_wp_q + 1'b1;
          end
          tx_cnt_d = tx_cnt_q + (TX_DEPTH_LOG2+1)'(tx_push[c]) - (TX_DEPTH_LOG2+1)'(tx_pop);
          if (rx_push) begin
            rx_mem_d[rx_wp_q] = uart_rxdata[8*c +: 8];
            rx_wp_d           = rx_wp_q + 1'b1;
          end
          if (rx_pop[c]) rx_rp_d = rx_rp_q + 1'b1;
          rx_cnt_d = rx_cnt_q + (RX_DEPTH_LOG2+1)'(rx_push) - (RX_DEPTH_LOG2+1)'(rx_pop[c]);
          if (ovr_clr[c]) ovr_d = 1'b0;
          if (uart_rxint[c] && !rx_push) ovr_d = 1'b1;
          if (div_we[c]) div_d = bus.mem_write[15:0];
          if (ien_we[c]) ien_d = bus.mem_write[1:0];
        end

        always_ff @(posedge clk) begin
          tx_mem_q <= tx_mem_d;
          rx_mem_q <= rx_mem_d;
        end

        always_ff @(posedge clk or negedge reset_in) begin
          if (!reset_in) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            tx_st_q   <= T_IDLE;
            tx_wait_q <= 1'b0;
            txgo_q    <= 1'b0;
            txdata_q  <= '0;
            ovr_q     <= 1'b0;
            div_q     <= DEFAULT_DIVISOR;
            ien_q     <= '0;
          end else begin
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_st_q   <= tx_st_d;
            tx_wait_q <= tx_wait_d;
            txgo_q    <= txgo_d;
            txdata_q  <= txdata_d;
            ovr_q     <= ovr_d;
            div_q     <= div_d;
            ien_q     <= ien_d;
          end
        end

        assign rx_ne[c]    = (rx_cnt_q != '0);
        assign tx_full[c]  = tx_cnt_q[TX_DEPTH_LOG2];
        assign tx_idle[c]  = (tx_cnt_q == '0) && uart_txready[c];
        assign ovr[c]      = ovr_q;
        assign rx_head[c]  = rx_mem_q[rx_rp_q];
        assign rx_cnt8[c]  = 8'(rx_cnt_q);
        assign tx_cnt8[c]  = 8'(tx_cnt_q);
        assign div[c]      = div_q;
        assign ien[c]      = ien_q;
        assign irq_src[c]  = (ien_q[0] & rx_ne[c]) | (ien_q[1] & tx_idle[c]);
        assign uart_txdata[8*c +: 8]   = txdata_q;
        assign uart_txgo[c]            = txgo_q;
        assign uart_divisor[16*c +: 16] = div_q;
      end else begin : g_off
        logic unused_ctl;
        assign unused_ctl = ^{tx_push[c], rx_pop[c], div_we[c], ien_we[c], ovr_clr[c]};
        assign rx_ne[c]   = 1'b0;
        assign tx_full[c] = 1'b0;
        assign tx_idle[c] = 1'b0;
        assign ovr[c]     = 1'b0;
        assign irq_src[c] = 1'b0;
        assign rx_head[c] = '0;
        assign rx_cnt8[c] = '0;
        assign tx_cnt8[c] = '0;
        assign div[c]     = '0;
        assign ien[c]     = '0;
      end
    end
  endgenerate
endmodule
